// File: rtl/ahbl_sram_pkg.sv
// Shared constants, FSM state type and helpers for the AHB-Lite to fabric SRAM bridge.
package ahbl_sram_pkg;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_ERR1    = 3'd3,
    ST_ERR2    = 3'd4
  } state_e;

  // Smallest r such that 2**r >= v.
  function automatic int unsigned ceil_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ahbl_sram_bridge_if.sv
// AHB-Lite signal bundle between the interconnect (master view) and the SRAM bridge (slave view).
interface ahbl_sram_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                  HSEL;
  logic                  HREADYIN;
  logic [1:0]            HTRANS;
  logic [2:0]            HBURST;
  logic [2:0]            HSIZE;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HREADYIN, HTRANS, HBURST, HSIZE, HADDR, HWRITE, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HREADYIN, HTRANS, HBURST, HSIZE, HADDR, HWRITE, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahbl_sram_byteen.sv
// HSIZE + low address bits to SRAM byte-lane enables, plus size/alignment legality.
// Oversize HSIZE is clamped to the bus width and misaligned offsets are truncated.
module ahbl_sram_byteen
  import ahbl_sram_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned NB         = DATA_WIDTH / 8,
  localparam int unsigned BL         = ceil_log2(NB)
) (
  input  logic [2:0]    size_i,
  input  logic [BL-1:0] off_i,
  output logic [NB-1:0] byteen_o,
  output logic          legal_o
);

  logic [2:0]    max_size;
  logic [2:0]    eff_size;
  logic [BL-1:0] size_mask;
  logic [BL-1:0] off_al;
  int unsigned   nbytes;

  always_comb begin
    byteen_o  = '0;
    max_size  = (NB == 8) ? HSIZE_DWORD : HSIZE_WORD;
    eff_size  = (size_i > max_size) ? max_size : size_i;
    nbytes    = 32'(1) << eff_size;
    size_mask = BL'(nbytes - 32'(1));
    off_al    = off_i & ~size_mask;
    for (int unsigned i = 0; i < NB; i++) begin
      byteen_o[i] = (i >= 32'(off_al)) && (i < (32'(off_al) + nbytes));
    end
    legal_o = (size_i <= max_size) && ((off_i & size_mask) == '0);
  end

endmodule

// File: rtl/ahbl_sram_bridge.sv
// AHB-Lite slave to single-port fabric SRAM bridge with RD_LAT read wait states and byte lanes.
// Define AHBL_SRAM_RANGE_ERR_EN to answer out-of-range/oversize/misaligned transfers with ERROR.
module ahbl_sram_bridge
  import ahbl_sram_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned MEM_DEPTH  = 65536,
  parameter  int unsigned RD_LAT     = 1,
  localparam int unsigned NB         = DATA_WIDTH / 8,
  localparam int unsigned BL         = ceil_log2(NB),
  localparam int unsigned MEM_AWIDTH = ceil_log2(MEM_DEPTH)
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahbl_sram_bridge_if.slave     ahb,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  output logic [NB-1:0]         mem_byteen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [MEM_AWIDTH-1:0]   waddr_q, waddr_d;
  logic [NB-1:0]           byteen_q, byteen_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;

  logic                    accept_c;
  logic                    ready_c;
  logic                    rd_last_c;
  logic                    illegal_c;
  logic [NB-1:0]           dec_byteen;
  logic                    dec_legal;

  logic                    hreadyout_c;
  logic [1:0]              hresp_c;
  logic [DATA_WIDTH-1:0]   hrdata_c;

  ahbl_sram_byteen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byteen (
    .size_i   (ahb.HSIZE),
    .off_i    (ahb.HADDR[BL-1:0]),
    .byteen_o (dec_byteen),
    .legal_o  (dec_legal)
  );

`ifdef AHBL_SRAM_RANGE_ERR_EN
  assign illegal_c = !dec_legal || (64'(ahb.HADDR >> BL) >= 64'(MEM_DEPTH));
  logic unused_ok;
  assign unused_ok = ^ahb.HBURST;
`else
  assign illegal_c = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{ahb.HBURST, dec_legal, ahb.HADDR[ADDR_WIDTH-1:MEM_AWIDTH+BL]};
`endif

  assign accept_c  = ahb.HSEL && ahb.HREADYIN &&
                     ((ahb.HTRANS == HTRANS_NONSEQ) || (ahb.HTRANS == HTRANS_SEQ));
  assign rd_last_c = (state_q == ST_RD_WAIT) && (cnt_q == 2'(RD_LAT));
  // A new address phase can only land in a cycle where this slave drives HREADYOUT=1.
  assign ready_c   = (state_q == ST_IDLE) || (state_q == ST_WR) ||
                     (state_q == ST_ERR2) || rd_last_c;

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (ready_c) begin
      if (!accept_c)       state_d = ST_IDLE;
      else if (illegal_c)  state_d = ST_ERR1;
      else if (ahb.HWRITE) state_d = ST_WR;
      else                 state_d = ST_RD_WAIT;
    end
  end

  // Data-phase registers: address/lanes, read-latency counter, held read data
  always_comb begin
    waddr_d  = waddr_q;
    byteen_d = byteen_q;
    cnt_d    = cnt_q;
    hrdata_d = hrdata_q;
    if ((state_q == ST_RD_WAIT) && !rd_last_c) cnt_d = cnt_q + 2'd1;
    if (rd_last_c) hrdata_d = mem_rdata;
    if (ready_c && accept_c) begin
      waddr_d  = ahb.HADDR[MEM_AWIDTH+BL-1:BL];
      byteen_d = dec_byteen;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      waddr_q  <= '0;
      byteen_q <= '0;
      cnt_q    <= '0;
      hrdata_q <= '0;
    end else begin
      waddr_q  <= waddr_d;
      byteen_q <= byteen_d;
      cnt_q    <= cnt_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Output decode; reset forces the idle bus/SRAM values in the same cycle
  always_comb begin
    hreadyout_c = 1'b1;
    hresp_c     = HRESP_OKAY;
    hrdata_c    = hrdata_q;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_byteen  = '0;
    mem_wdata   = '0;
    if (HRESET) begin
      hrdata_c = '0;
    end else begin
      case (state_q)
        ST_WR: begin
          mem_wen    = 1'b1;
          mem_addr   = waddr_q;
          mem_byteen = byteen_q;
          mem_wdata  = ahb.HWDATA;
        end
        ST_RD_WAIT: begin
          mem_ren     = (cnt_q == 2'd0);
          mem_addr    = waddr_q;
          mem_byteen  = byteen_q;
          hreadyout_c = rd_last_c;
          if (rd_last_c) hrdata_c = mem_rdata;
        end
        ST_ERR1: begin
          hreadyout_c = 1'b0;
          hresp_c     = HRESP_ERROR;
        end
        ST_ERR2: begin
          hresp_c = HRESP_ERROR;
        end
        default: ;
      endcase
    end
  end

  assign ahb.HREADYOUT = hreadyout_c;
  assign ahb.HRESP     = hresp_c;
  assign ahb.HRDATA    = hrdata_c;

endmodule

// File: tb/tb_ahbl_sram_bridge.sv
// Directed bench for ahbl_sram_bridge (DW=32, MEM_DEPTH=1024, RD_LAT=2) with a behavioural SRAM.
module tb_ahbl_sram_bridge;
  import ahbl_sram_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        mem_ren, mem_wen;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_s1 = '0;
  logic [31:0] rd_s2 = '0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  logic        both_seen = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahbl_sram_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  assign bus.HREADYIN = bus.HREADYOUT;

  ahbl_sram_bridge #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH),
    .RD_LAT     (LAT)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .ahb        (bus),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // SRAM model: byte-lane writes, read data valid LAT cycles after mem_ren
  assign mem_rdata = (LAT == 1) ? rd_s1 : rd_s2;
  always @(posedge HCLK) begin
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_ren) rd_s1 <= mem[mem_addr];
    rd_s2 <= rd_s1;
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (mem_wen) wen_cnt <= wen_cnt + 1;
    if (mem_ren && mem_wen) both_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [1:0] tr);
    bus.HSEL   = 1'b1;
    bus.HTRANS = tr;
    bus.HBURST = 3'b011;
    bus.HADDR  = a;
    bus.HWRITE = wr;
    bus.HSIZE  = sz;
  endtask

  task automatic bus_idle;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                          input logic [3:0] exp_be, input logic [9:0] exp_addr, input string tag);
    addr_ph(1'b1, a, sz, 2'b10);
    tick;
    bus.HWDATA = d;
    bus_idle;
    @(negedge HCLK);
    chk({tag, "_wen"},   32'(mem_wen), 32'h1);
    chk({tag, "_be"},    32'(mem_byteen), 32'(exp_be));
    chk({tag, "_addr"},  32'(mem_addr), 32'(exp_addr));
    chk({tag, "_wdata"}, mem_wdata, d);
    chk({tag, "_rdy"},   32'(bus.HREADYOUT), 32'h1);
    tick;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] d,
                         output int waits, output logic [3:0] be, output logic [9:0] addr0,
                         output logic ren0, output logic [1:0] resp);
    addr_ph(1'b0, a, sz, 2'b10);
    tick;
    bus_idle;
    waits = 0;
    @(negedge HCLK);
    be    = mem_byteen;
    addr0 = mem_addr;
    ren0  = mem_ren;
    while (!bus.HREADYOUT && waits < 8) begin
      waits++;
      tick;
      @(negedge HCLK);
    end
    d    = bus.HRDATA;
    resp = bus.HRESP;
    tick;
  endtask

  logic [31:0] bd [4];
  logic [31:0] rdv;
  logic [3:0]  be;
  logic [9:0]  a0;
  logic        r0;
  logic [1:0]  rsp;
  int          waits, cyc, beat, r_before, w_before;

  initial begin
    bd[0] = 32'h0101_0101; bd[1] = 32'h2222_3333; bd[2] = 32'hA5A5_5A5A; bd[3] = 32'h8000_0001;
    bus_idle;
    bus.HADDR = '0; bus.HSIZE = 3'b010; bus.HBURST = 3'b000;
    bus.HWDATA = 32'hFFFF_FFFF;
    HRESET = 1'b1;
    repeat (2) tick;
    @(negedge HCLK);
    chk("rst_hready", 32'(bus.HREADYOUT), 32'h1);
    chk("rst_hresp",  32'(bus.HRESP), 32'h0);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    chk("rst_strobes", 32'({mem_ren, mem_wen}), 32'h0);
    chk("rst_addr_be", 32'({mem_addr, mem_byteen}), 32'h0);
    chk("rst_wdata",  mem_wdata, 32'h0);
    tick;
    HRESET = 1'b0;
    tick;

    // Single word write then read
    w_before = wen_cnt;
    do_write(32'h10, 3'b010, 32'hDEAD_BEEF, 4'hF, 10'd4, "t1_wr");
    chk("t1_wen_pulses", 32'(wen_cnt - w_before), 32'd1);
    do_read(32'h10, 3'b010, rdv, waits, be, a0, r0, rsp);
    chk("t1_rd_waits", 32'(waits), LAT);
    chk("t1_rd_data",  rdv, 32'hDEAD_BEEF);
    chk("t1_rd_ren",   32'(r0), 32'h1);
    chk("t1_rd_be",    32'(be), 32'hF);
    chk("t1_rd_resp",  32'(rsp), 32'h0);
    @(negedge HCLK);
    chk("t1_hold", bus.HRDATA, 32'hDEAD_BEEF);
    tick;

    // Byte and halfword lanes
    do_write(32'h20, 3'b010, 32'h1122_3344, 4'hF, 10'd8, "t2_base");
    do_write(32'h21, 3'b000, 32'h0000_AA00, 4'h2, 10'd8, "t2_b1");
    do_write(32'h23, 3'b000, 32'h5500_0000, 4'h8, 10'd8, "t2_b3");
    do_read(32'h20, 3'b010, rdv, waits, be, a0, r0, rsp);
    chk("t2_rd_data", rdv, 32'h5522_AA44);
    do_write(32'h22, 3'b001, 32'h7766_0000, 4'hC, 10'd8, "t2_h");
    do_read(32'h20, 3'b010, rdv, waits, be, a0, r0, rsp);
    chk("t2_rd_half", rdv, 32'h7766_AA44);
`ifndef AHBL_SRAM_RANGE_ERR_EN
    do_write(32'h23, 3'b001, 32'h9988_0000, 4'hC, 10'd8, "t2_mis");
    do_read(32'h20, 3'b010, rdv, waits, be, a0, r0, rsp);
    chk("t2_rd_mis", rdv, 32'h9988_AA44);
`endif

    // INCR4 write burst, pipelined, no wait states
    w_before = wen_cnt;
    waits = 0;
    addr_ph(1'b1, 32'h40, 3'b010, 2'b10);
    tick;
    for (int i = 0; i < 4; i++) begin
      bus.HWDATA = bd[i];
      if (i < 3) addr_ph(1'b1, 32'h40 + 32'(4 * (i + 1)), 3'b010, 2'b11);
      else       bus_idle;
      @(negedge HCLK);
      if (!bus.HREADYOUT) waits++;
      tick;
    end
    chk("t3_wr_waits", 32'(waits), 32'd0);
    chk("t3_wr_pulses", 32'(wen_cnt - w_before), 32'd4);

    // INCR4 read burst
    addr_ph(1'b0, 32'h40, 3'b010, 2'b10);
    tick;
    addr_ph(1'b0, 32'h44, 3'b010, 2'b11);
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 40) begin
      @(negedge HCLK);
      cyc++;
      if (bus.HREADYOUT) begin
        chk($sformatf("t3_rd_d%0d", beat), bus.HRDATA, bd[beat]);
        beat++;
        tick;
        if (beat + 1 < 4) addr_ph(1'b0, 32'h40 + 32'(4 * (beat + 1)), 3'b010, 2'b11);
        else              bus_idle;
      end else begin
        tick;
      end
    end
    chk("t3_rd_cycles", 32'(cyc), 32'(4 * (1 + LAT)));
    chk("t3_rd_beats",  32'(beat), 32'd4);

    // Out-of-range read at 0x1000 (word 1024)
    do_write(32'h0, 3'b010, 32'hCAFE_F00D, 4'hF, 10'd0, "t4_w0");
    r_before = ren_cnt;
`ifdef AHBL_SRAM_RANGE_ERR_EN
    addr_ph(1'b0, 32'h1000, 3'b010, 2'b10);
    tick;
    bus_idle;
    @(negedge HCLK);
    chk("t4_err1_rdy",  32'(bus.HREADYOUT), 32'h0);
    chk("t4_err1_resp", 32'(bus.HRESP), 32'h1);
    tick;
    @(negedge HCLK);
    chk("t4_err2_rdy",  32'(bus.HREADYOUT), 32'h1);
    chk("t4_err2_resp", 32'(bus.HRESP), 32'h1);
    tick;
    chk("t4_no_ren", 32'(ren_cnt - r_before), 32'd0);
`else
    do_read(32'h1000, 3'b010, rdv, waits, be, a0, r0, rsp);
    chk("t5_resp",  32'(rsp), 32'h0);
    chk("t5_ren",   32'(r0), 32'h1);
    chk("t5_addr",  32'(a0), 32'h0);
    chk("t5_data",  rdv, 32'hCAFE_F00D);
    chk("t5_waits", 32'(waits), LAT);
`endif

    // Reset in the first wait cycle of a read
    addr_ph(1'b0, 32'h10, 3'b010, 2'b10);
    tick;
    bus_idle;
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("t6_rst_ren", 32'(mem_ren), 32'h0);
    r_before = ren_cnt;
    tick;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("t6_rdy",    32'(bus.HREADYOUT), 32'h1);
    chk("t6_hrdata", bus.HRDATA, 32'h0);
    chk("t6_state",  32'(dut.state_q), 32'(ST_IDLE));
    repeat (4) tick;
    chk("t6_no_ren", 32'(ren_cnt - r_before), 32'd0);
    chk("strobe_excl", 32'(both_seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
